// File: rtl/ah_arb_pkg.sv
// ah_arb_pkg: shared helpers for the AH arbiter requester front end
// Provides clog2, the default source-index type and the FIFO slot reservation rule.
package ah_arb_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int N_DEF = 16;
    localparam int SRC_W = clog2(N_DEF);
    typedef logic [SRC_W-1:0] src_t;

    // One slot stays free for the grant that may already be in flight from last cycle's req.
    function automatic logic slot_free(input int cnt, input logic req_q, input int depth);
        return (cnt + int'(req_q)) < depth;
    endfunction

endpackage

// File: rtl/ah_arb_requester_if.sv
// ah_arb_requester_if: client, arbiter and downstream signals of the requester
// master: requester side (drives in_ready/req/out_*/starve/err); slave: environment side.
interface ah_arb_requester_if import ah_arb_pkg::*; #(
    parameter int N  = 16,
    parameter int DW = 32
);
    localparam int SW = clog2(N);
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic [N-1:0]    starve;
    logic            err;

    modport master (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, req, out_valid, out_data, out_src, starve, err
    );

    modport slave (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, req, out_valid, out_data, out_src, starve, err
    );
endinterface

// File: rtl/ah_sync_fifo.sv
// ah_sync_fifo: small synchronous FIFO with occupancy count
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, cnt, full, empty.
// rdata reads as zero while empty.
module ah_sync_fifo import ah_arb_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic [clog2(DEPTH+1)-1:0]   cnt,
    output logic                        full,
    output logic                        empty
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign cnt     = cnt_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem_q[rp_q];

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (do_push) begin
            mem_d[wp_q] = wdata;
            wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
        end
        if (do_pop) rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/ah_arb_requester.sv
// ah_arb_requester: requester-side front end for the AH round-robin arbiters
// Ports: clk, rst (sync, active-high), bus (master modport): per-client in_valid/in_ready/in_data,
// arbiter req/gnt, downstream out_valid/out_ready/out_data/out_src, starve flags and sticky err.
module ah_arb_requester import ah_arb_pkg::*; #(
    parameter int N          = 16,
    parameter int DW         = 32,
    parameter int OUT_DEPTH  = 2,
    parameter int STARVE_MAX = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    ah_arb_requester_if.master    bus
);
    localparam int SW = clog2(N);
    localparam int WW = clog2(STARVE_MAX+1);
    localparam int CW = clog2(OUT_DEPTH+1);

    logic [N-1:0]     hv_q, hv_d;
    logic [DW-1:0]    hd_q [N];
    logic [DW-1:0]    hd_d [N];
    logic [WW-1:0]    wc_q [N];
    logic [WW-1:0]    wc_d [N];
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [N-1:0]     gv, take, starve;
    logic [SW-1:0]    sel;
    logic             push, full, empty;
    logic [CW-1:0]    cnt;
    logic [SW+DW-1:0] rdata;

    assign bus.in_ready  = ~hv_q;
    assign bus.req       = hv_q & {N{slot_free(int'(cnt), req_q, OUT_DEPTH)}};
    assign bus.out_valid = ~empty;
    assign bus.starve    = starve;
    assign bus.err       = err_q;
    assign {bus.out_src, bus.out_data} = rdata;
    assign req_d = |bus.req;
    assign gv    = bus.gnt & hv_q;
    assign push  = |gv;
    assign take  = push ? (N'(1) << sel) : '0;

    // Lowest granted client holding a word wins when several gnt bits are set.
    always_comb begin
        sel = '0;
        for (int i = N-1; i >= 0; i--) if (gv[i]) sel = SW'(i);
    end

    always_comb begin
        hv_d  = hv_q;
        hd_d  = hd_q;
        wc_d  = wc_q;
        err_d = err_q | (|(bus.gnt & ~hv_q)) | (|(bus.gnt & (bus.gnt - N'(1))));
        for (int i = 0; i < N; i++) begin
            starve[i] = hv_q[i] & (wc_q[i] == WW'(STARVE_MAX));
            wc_d[i] = (~hv_q[i] | take[i]) ? '0 : (wc_q[i] == WW'(STARVE_MAX)) ? wc_q[i] : wc_q[i] + 1'b1;
            if (take[i]) hv_d[i] = 1'b0;
            if (bus.in_valid[i] & ~hv_q[i]) begin
                hv_d[i] = 1'b1;
                hd_d[i] = bus.in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q  <= '0;
            req_q <= 1'b0;
            err_q <= 1'b0;
            wc_q  <= '{default: '0};
        end else begin
            hv_q  <= hv_d;
            req_q <= req_d;
            err_q <= err_d;
            wc_q  <= wc_d;
        end
    end

    always_ff @(posedge clk) hd_q <= hd_d;

    ah_sync_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(SW+DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push & ~full),
        .wdata ({sel, hd_q[sel]}),
        .pop   (bus.out_valid & bus.out_ready),
        .rdata (rdata),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ah_arb_requester.sv
// tb_ah_arb_requester: vector table, corner sequences and random traffic against a queue model
module tb_ah_arb_requester;
    localparam int N    = 16;
    localparam int DW   = 32;
    localparam int SMAX = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ah_arb_requester_if #(.N(N), .DW(DW)) bus();

    ah_arb_requester #(.N(N), .DW(DW), .OUT_DEPTH(2), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit          m_hv [N];
    logic [31:0] m_hd [N];
    int          m_wc [N];
    logic [35:0] m_q [$];
    bit          m_reqq;
    bit          m_err;

    int         rr = N-1;
    bit         arb_en = 1'b0;
    int         arb_pct = 100;
    logic [3:0] gq [$];
    logic [3:0] pq [$];

    typedef struct {
        bit          rst;
        logic [15:0] iv;
        logic [15:0] gnt;
        bit          ordy;
        logic [15:0] e_req;
        logic [15:0] e_ir;
        bit          e_ov;
        logic [3:0]  e_src;
        logic [31:0] e_data;
        bit          e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_hv[i] && (m_q.size() + int'(m_reqq) < 2);
        return r;
    endfunction

    task automatic step();
        logic [N-1:0] r;
        logic [N-1:0] eir, est, cand;
        bit old [N];
        int gi;
        bit found;
        r = m_req();
        gi = -1;
        if (bus.out_valid && bus.out_ready) pq.push_back(bus.out_src);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_hv[i] = 0;
                m_wc[i] = 0;
            end
            m_q.delete();
            m_reqq = 0;
            m_err = 0;
        end else begin
            old = m_hv;
            if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
            if ($countones(bus.gnt) > 1) m_err = 1;
            for (int i = 0; i < N; i++)
                if (bus.gnt[i]) begin
                    if (!old[i]) m_err = 1;
                    else if (gi < 0) gi = i;
                end
            if (gi >= 0) begin
                m_q.push_back({4'(gi), m_hd[gi]});
                m_hv[gi] = 0;
            end
            for (int i = 0; i < N; i++)
                m_wc[i] = (!old[i] || i == gi) ? 0 : (m_wc[i] < SMAX ? m_wc[i] + 1 : SMAX);
            for (int i = 0; i < N; i++)
                if (bus.in_valid[i] && !old[i]) begin
                    m_hv[i] = 1;
                    m_hd[i] = bus.in_data[i*DW +: DW];
                end
            m_reqq = |r;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            eir[i] = !m_hv[i];
            est[i] = m_hv[i] && m_wc[i] == SMAX;
        end
        chk("m_in_ready", bus.in_ready, eir);
        chk("m_req", bus.req, m_req());
        chk("m_out_valid", bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("m_out_src", bus.out_src, m_q[0][35:32]);
            chk("m_out_data", bus.out_data, m_q[0][31:0]);
        end
        chk("m_starve", bus.starve, est);
        chk("m_err", bus.err, m_err);
        if (arb_en) begin
            cand = bus.req & ~bus.gnt;
            bus.gnt = '0;
            found = 0;
            if (cand != '0 && $urandom_range(99) < arb_pct)
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
                    if (!found && cand[idx]) begin
                        found = 1;
                        bus.gnt[idx] = 1'b1;
                        rr = idx;
                        gq.push_back(4'(idx));
                    end
                end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        bus.in_valid = '0;
        bus.gnt = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] cover_m;
        bus.in_valid = '0;
        bus.gnt = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);

        tbl[0]  = '{1, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 0};
        tbl[1]  = '{1, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 0};
        tbl[2]  = '{0, 16'h0020, 16'h0000, 0, 16'h0020, 16'hFFDF, 0, 4'd0, 32'h0, 0};
        tbl[3]  = '{0, 16'h0000, 16'h0000, 0, 16'h0020, 16'hFFDF, 0, 4'd0, 32'h0, 0};
        tbl[4]  = '{0, 16'h0000, 16'h0020, 0, 16'h0000, 16'hFFFF, 1, 4'd5, 32'hA5A5_0005, 0};
        tbl[5]  = '{0, 16'h0000, 16'h0000, 1, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 0};
        tbl[6]  = '{0, 16'h0000, 16'h0100, 0, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 1};
        tbl[7]  = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 1};
        tbl[8]  = '{0, 16'h0003, 16'h0000, 0, 16'h0003, 16'hFFFC, 0, 4'd0, 32'h0, 1};
        tbl[9]  = '{0, 16'h0000, 16'h0003, 0, 16'h0000, 16'hFFFD, 1, 4'd0, 32'hA5A5_0000, 1};
        tbl[10] = '{0, 16'h0000, 16'h0000, 1, 16'h0002, 16'hFFFD, 0, 4'd0, 32'h0, 1};
        tbl[11] = '{0, 16'h0000, 16'h0002, 0, 16'h0000, 16'hFFFF, 1, 4'd1, 32'hA5A5_0001, 1};
        tbl[12] = '{0, 16'h0000, 16'h0000, 1, 16'h0000, 16'hFFFF, 0, 4'd0, 32'h0, 1};

        for (int k = 0; k < 13; k++) begin
            rst = tbl[k].rst;
            bus.in_valid = tbl[k].iv;
            bus.gnt = tbl[k].gnt;
            bus.out_ready = tbl[k].ordy;
            step();
            chk($sformatf("v%0d_req", k), bus.req, tbl[k].e_req);
            chk($sformatf("v%0d_in_ready", k), bus.in_ready, tbl[k].e_ir);
            chk($sformatf("v%0d_out_valid", k), bus.out_valid, tbl[k].e_ov);
            chk($sformatf("v%0d_err", k), bus.err, tbl[k].e_err);
            if (tbl[k].e_ov) begin
                chk($sformatf("v%0d_out_src", k), bus.out_src, tbl[k].e_src);
                chk($sformatf("v%0d_out_data", k), bus.out_data, tbl[k].e_data);
            end
        end
        bus.gnt = '0;
        bus.in_valid = '0;

        // Backpressure: everyone loads, only two words may enter the FIFO.
        pulse_rst();
        for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = $urandom;
        bus.out_ready = 1'b0;
        bus.in_valid = 16'hFFFF;
        step();
        bus.in_valid = '0;
        gq.delete();
        pq.delete();
        arb_en = 1;
        arb_pct = 100;
        repeat (10) step();
        chk("bp_grants", gq.size(), 2);
        chk("bp_req", bus.req, 16'h0000);
        chk("bp_err", bus.err, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 300 && pq.size() < 16; c++) step();
        arb_en = 0;
        bus.gnt = '0;
        chk("bp_pops", pq.size(), 16);
        cover_m = '0;
        for (int k = 0; k < pq.size() && k < gq.size(); k++) begin
            chk($sformatf("bp_order%0d", k), pq[k], gq[k]);
            cover_m[pq[k]] = 1'b1;
        end
        chk("bp_cover", cover_m, 16'hFFFF);
        chk("bp_err_end", bus.err, 0);

        // Starvation of client 3 with grants withheld.
        pulse_rst();
        bus.in_valid = 16'h0008;
        step();
        bus.in_valid = '0;
        repeat (62) step();
        chk("starve_pre", bus.starve[3], 0);
        step();
        chk("starve_set", bus.starve[3], 1);
        bus.gnt = 16'h0008;
        step();
        bus.gnt = '0;
        chk("starve_clr", bus.starve[3], 0);

        // Reset with a full FIFO and eight held words.
        pulse_rst();
        bus.out_ready = 1'b0;
        bus.in_valid = 16'h0300;
        step();
        bus.in_valid = '0;
        bus.gnt = 16'h0100;
        step();
        bus.gnt = 16'h0200;
        bus.in_valid = 16'h00FF;
        step();
        bus.gnt = '0;
        bus.in_valid = '0;
        chk("mr_full_valid", bus.out_valid, 1);
        chk("mr_hv", bus.in_ready, 16'hFF00);
        chk("mr_req_blocked", bus.req, 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_in_ready", bus.in_ready, 16'hFFFF);
        chk("mr_req", bus.req, 16'h0000);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("mr_no_stale", bus.out_valid, 0);
        end

        // Random traffic against the model.
        pulse_rst();
        arb_en = 1;
        arb_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = 16'($urandom) & 16'($urandom);
            for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = $urandom;
            bus.out_ready = ($urandom_range(3) != 0);
            step();
        end
        arb_en = 0;
        bus.gnt = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
